shift_register_ctrl: RTL and testbench

SHIFT_REGISTER_CTRL -- requirements
Module: shift_register_ctrl

---
 rtl/shift_register_pkg.sv | 17 +
 rtl/shift_register_ctrl_if.sv | 24 ++
 rtl/shift_register_ctrl_fsm.sv | 64 ++++++
 rtl/shift_register_ctrl.sv | 68 ++++++
 tb/tb_shift_register_ctrl.sv | 169 ++++++++++++++++
 5 files changed

// File: rtl/shift_register_pkg.sv
// Shared types and constants for the shift-register transfer controller.
package shift_register_pkg;

    localparam int unsigned NbitDefault = 8;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StShift = 2'd1,
        StDone  = 2'd2
    } state_e;

    // Bit counter must reach NBIT, hence the +1.
    function automatic int unsigned cnt_width(input int unsigned nbit);
        return $clog2(nbit + 1);
    endfunction

endpackage

// File: rtl/shift_register_ctrl_if.sv
// Parallel-load / serial-shift handshake bundle between a requester and the controller.
interface shift_register_ctrl_if #(
    parameter int unsigned NBIT = shift_register_pkg::NbitDefault
);
    logic            i_valid;
    logic            o_ready;
    logic [NBIT-1:0] i_data;
    logic            i_clr;
    logic            i_sdi;
    logic            o_sdo;
    logic            o_busy;
    logic            o_done;
    logic [NBIT-1:0] o_rdata;

    modport slave (
        input  i_valid, i_data, i_clr, i_sdi,
        output o_ready, o_sdo, o_busy, o_done, o_rdata
    );

    modport master (
        output i_valid, i_data, i_clr, i_sdi,
        input  o_ready, o_sdo, o_busy, o_done, o_rdata
    );
endinterface

// File: rtl/shift_register_ctrl_fsm.sv
// Transfer sequencer: owns state and bit counter, emits load/shift/last strobes and a
// registered done pulse.
module shift_register_ctrl_fsm
    import shift_register_pkg::*;
#(
    parameter int unsigned NBIT = NbitDefault
) (
    input  logic   i_clk,
    input  logic   i_rstn,
    input  logic   i_valid,
    input  logic   i_clr,
    output state_e o_state,
    output logic   o_load,
    output logic   o_shift,
    output logic   o_last,
    output logic   o_done
);

    localparam int unsigned CntW = cnt_width(NBIT);
    localparam logic [CntW-1:0] LastCnt = CntW'(NBIT - 1);

    state_e          state_q;
    logic [CntW-1:0] cnt_q;
    logic            done_q;

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (i_clr) begin
                state_q <= StIdle;
                cnt_q   <= '0;
            end else begin
                unique case (state_q)
                    StIdle: begin
                        if (i_valid) begin
                            state_q <= StShift;
                            cnt_q   <= '0;
                        end
                    end
                    StShift: begin
                        cnt_q <= cnt_q + 1'b1;
                        if (cnt_q == LastCnt) begin
                            state_q <= StDone;
                            done_q  <= 1'b1;
                        end
                    end
                    StDone:  state_q <= StIdle;
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

    assign o_state = state_q;
    assign o_load  = (state_q == StIdle) && i_valid && !i_clr;
    assign o_shift = (state_q == StShift) && !i_clr;
    assign o_last  = o_shift && (cnt_q == LastCnt);
    assign o_done  = done_q;

endmodule

// File: rtl/shift_register_ctrl.sv
// Serializes a parallel word MSB first while capturing i_sdi; the captured word is
// published on o_rdata at the edge that enters DONE.
module shift_register_ctrl
    import shift_register_pkg::*;
#(
    parameter int unsigned NBIT = NbitDefault
) (
    input logic                  i_clk,
    input logic                  i_rstn,
    shift_register_ctrl_if.slave bus
);

    state_e          state;
    logic            load;
    logic            shift;
    logic            last;
    logic            done;
    logic [NBIT-1:0] sreg_q, sreg_d;
    logic [NBIT-1:0] rdata_q, rdata_d;
    logic [NBIT-1:0] sreg_shifted;

    shift_register_ctrl_fsm #(
        .NBIT (NBIT)
    ) u_fsm (
        .i_clk   (i_clk),
        .i_rstn  (i_rstn),
        .i_valid (bus.i_valid),
        .i_clr   (bus.i_clr),
        .o_state (state),
        .o_load  (load),
        .o_shift (shift),
        .o_last  (last),
        .o_done  (done)
    );

    assign sreg_shifted = {sreg_q[NBIT-2:0], bus.i_sdi};

    always_comb begin
        sreg_d  = sreg_q;
        rdata_d = rdata_q;
        if (load) begin
            sreg_d = bus.i_data;
        end else if (shift) begin
            sreg_d = sreg_shifted;
        end
        // Capture the post-shift value so o_rdata is already valid in the DONE cycle.
        if (last) begin
            rdata_d = sreg_shifted;
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            sreg_q  <= '0;
            rdata_q <= '0;
        end else begin
            sreg_q  <= sreg_d;
            rdata_q <= rdata_d;
        end
    end

    assign bus.o_ready = (state == StIdle);
    assign bus.o_busy  = (state == StShift) || (state == StDone);
    assign bus.o_sdo   = (state == StShift) && sreg_q[NBIT-1];
    assign bus.o_done  = done;
    assign bus.o_rdata = rdata_q;

endmodule

// File: tb/tb_shift_register_ctrl.sv
// Bench for shift_register_ctrl: scripted transfers, expected words queued at accept time
// and retired whenever o_done is seen.
module tb_shift_register_ctrl;

    localparam int unsigned NBIT = 8;

    logic clk;
    logic rstn;

    int n_checks = 0;
    int n_fail   = 0;
    logic [NBIT-1:0] exp_q[$];

    shift_register_ctrl_if #(.NBIT(NBIT)) bus ();

    shift_register_ctrl #(
        .NBIT (NBIT)
    ) dut (
        .i_clk  (clk),
        .i_rstn (rstn),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Every o_done must retire exactly one queued word.
    always @(negedge clk) begin
        if (rstn && bus.o_done) begin
            if (exp_q.size() == 0) begin
                check_eq("done_without_transfer", 32'(bus.o_done), 32'd0);
            end else begin
                check_eq("sb_rdata", 32'(bus.o_rdata), 32'(exp_q.pop_front()));
            end
        end
    end

    // Called at a negedge in IDLE; returns at the negedge following the accept edge E0.
    task automatic start_xfer(input logic [NBIT-1:0] d, input logic [NBIT-1:0] exp,
                              input bit push, input bit hold_valid);
        check_eq("ready_before_accept", 32'(bus.o_ready), 32'd1);
        bus.i_valid = 1'b1;
        bus.i_data  = d;
        if (push) exp_q.push_back(exp);
        @(posedge clk);
        @(negedge clk);
        if (!hold_valid) bus.i_valid = 1'b0;
    endtask

    // Walks the NBIT SHIFT cycles and the DONE cycle; returns at the negedge of IDLE.
    task automatic shift_phase(input logic [NBIT-1:0] d, input bit loop, input bit sdi_c,
                               input int pulse_at);
        logic [NBIT-1:0] exp;
        exp = loop ? d : {NBIT{sdi_c}};
        for (int i = 0; i < int'(NBIT); i++) begin
            check_eq($sformatf("sdo_bit%0d", i), 32'(bus.o_sdo), 32'(d[NBIT-1-i]));
            check_eq("busy_shift", 32'(bus.o_busy), 32'd1);
            check_eq("ready_shift", 32'(bus.o_ready), 32'd0);
            check_eq("done_shift", 32'(bus.o_done), 32'd0);
            bus.i_sdi = loop ? d[NBIT-1-i] : sdi_c;
            if (i == pulse_at) begin
                bus.i_valid = 1'b1;
                bus.i_data  = 8'hFF;
            end else if (i == pulse_at + 1) begin
                bus.i_valid = 1'b0;
            end
            @(negedge clk);
        end
        check_eq("done_pulse", 32'(bus.o_done), 32'd1);
        check_eq("busy_done", 32'(bus.o_busy), 32'd1);
        check_eq("ready_done", 32'(bus.o_ready), 32'd0);
        check_eq("sdo_done", 32'(bus.o_sdo), 32'd0);
        check_eq("rdata_done", 32'(bus.o_rdata), 32'(exp));
        @(negedge clk);
    endtask

    task automatic idle_check(input logic [NBIT-1:0] exp_rdata, input int n);
        for (int i = 0; i < n; i++) begin
            check_eq("ready_idle", 32'(bus.o_ready), 32'd1);
            check_eq("busy_idle", 32'(bus.o_busy), 32'd0);
            check_eq("done_idle", 32'(bus.o_done), 32'd0);
            check_eq("sdo_idle", 32'(bus.o_sdo), 32'd0);
            check_eq("rdata_hold", 32'(bus.o_rdata), 32'(exp_rdata));
            @(negedge clk);
        end
    endtask

    initial begin
        rstn        = 1'b0;
        bus.i_valid = 1'b0;
        bus.i_data  = '0;
        bus.i_clr   = 1'b0;
        bus.i_sdi   = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("rst_ready", 32'(bus.o_ready), 32'd1);
        check_eq("rst_busy", 32'(bus.o_busy), 32'd0);
        check_eq("rst_done", 32'(bus.o_done), 32'd0);
        check_eq("rst_sdo", 32'(bus.o_sdo), 32'd0);
        check_eq("rst_rdata", 32'(bus.o_rdata), 32'd0);

        // First accept on the very first edge after release, loopback 0xA5.
        rstn = 1'b1;
        start_xfer(8'hA5, 8'hA5, 1'b1, 1'b0);
        shift_phase(8'hA5, 1'b1, 1'b0, -1);
        idle_check(8'hA5, 2);

        // All-zero word out, constant ones in.
        start_xfer(8'h00, 8'hFF, 1'b1, 1'b0);
        shift_phase(8'h00, 1'b0, 1'b1, -1);
        idle_check(8'hFF, 2);

        // Back-to-back with i_valid held high; data changes only after the accept edge.
        start_xfer(8'h3C, 8'h3C, 1'b1, 1'b1);
        bus.i_data = 8'hC3;
        shift_phase(8'h3C, 1'b1, 1'b0, -1);
        start_xfer(8'hC3, 8'hC3, 1'b1, 1'b0);
        shift_phase(8'hC3, 1'b1, 1'b0, -1);
        idle_check(8'hC3, 2);

        start_xfer(8'h3C, 8'h3C, 1'b1, 1'b0);
        shift_phase(8'h3C, 1'b1, 1'b0, -1);
        idle_check(8'h3C, 1);

        // Abort at cnt==3: no done, o_rdata keeps 0x3C.
        start_xfer(8'h55, 8'h00, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        check_eq("busy_before_clr", 32'(bus.o_busy), 32'd1);
        bus.i_clr = 1'b1;
        @(negedge clk);
        bus.i_clr = 1'b0;
        idle_check(8'h3C, 10);

        // A valid pulse during SHIFT must not start a second transfer.
        start_xfer(8'h12, 8'h12, 1'b1, 1'b0);
        shift_phase(8'h12, 1'b1, 1'b0, 3);
        idle_check(8'h12, 10);

        // Asynchronous reset mid-SHIFT at cnt==4.
        start_xfer(8'hA5, 8'h00, 1'b0, 1'b0);
        repeat (4) @(negedge clk);
        #2 rstn = 1'b0;
        #1;
        check_eq("arst_ready", 32'(bus.o_ready), 32'd1);
        check_eq("arst_busy", 32'(bus.o_busy), 32'd0);
        check_eq("arst_done", 32'(bus.o_done), 32'd0);
        check_eq("arst_sdo", 32'(bus.o_sdo), 32'd0);
        check_eq("arst_rdata", 32'(bus.o_rdata), 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        idle_check(8'h00, 10);

        start_xfer(8'h5A, 8'h5A, 1'b1, 1'b0);
        shift_phase(8'h5A, 1'b1, 1'b0, -1);
        idle_check(8'h5A, 2);

        check_eq("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
